// File: rtl/pipe_ctrl_unit.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_unit
//   Registered EX-stage control for the pipelined MIPS-subset core. Decodes
//   the instruction leaving the instruction register into EX control, and
//   owns the hi/lo multiply interlock, the branch-resolution squash FSM and
//   the GPIO channel strobes.
//
// Ports
//   clk, rst          core clock, asynchronous active-high reset
//   instr_valid       instruction input valid this cycle
//   instruction[31:0] instruction to decode
//   zero_EX           ALU zero flag of the instruction now in EX
//   stall_out         hold fetch / instruction register (combinational)
//   valid_EX          EX slot holds a real instruction
//   alu_op[3:0]       ALU operation
//   shamt_EX[4:0]     shift amount
//   regsel_EX[1:0]    write-back select: 0 ALU, 1 hi, 2 lo, 3 GPIO
//   enhilo_EX         load hi/lo
//   regwrite_EX       register-file write enable
//   rdrt_EX           destination select: 0 rd, 1 rt
//   alu_src_EX[1:0]   B operand: 0 rt, 1 sign-ext imm, 2 zero-ext imm
//   pc_src_EX[1:0]    next PC: 0 PC+4, 1 branch target (combinational)
//   gpio_out_en       one-hot GPIO write strobe
//   gpio_in_en        one-hot GPIO read select
//   illegal_EX        unrecognised opcode / funct
// ----------------------------------------------------------------------------
module pipe_ctrl_unit #(
    parameter int GPIO_CH    = 4,
    parameter int MULT_LAT   = 4,
    parameter int DELAY_SLOT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [31:0]        instruction,
    input  logic               zero_EX,
    output logic               stall_out,
    output logic               valid_EX,
    output logic [3:0]         alu_op,
    output logic [4:0]         shamt_EX,
    output logic [1:0]         regsel_EX,
    output logic               enhilo_EX,
    output logic               regwrite_EX,
    output logic               rdrt_EX,
    output logic [1:0]         alu_src_EX,
    output logic [1:0]         pc_src_EX,
    output logic [GPIO_CH-1:0] gpio_out_en,
    output logic [GPIO_CH-1:0] gpio_in_en,
    output logic               illegal_EX
);

    // Counter only has to hold MULT_LAT-1.
    localparam int MW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_RESOLVE = 1'b1;

    localparam logic [GPIO_CH-1:0] CH_ONE = {{(GPIO_CH-1){1'b0}}, 1'b1};

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef struct packed {
        logic               valid;
        logic [3:0]         alu_op;
        logic [4:0]         shamt;
        logic [1:0]         regsel;
        logic               enhilo;
        logic               regwrite;
        logic               rdrt;
        logic [1:0]         alu_src;
        logic               is_beq;
        logic               is_bne;
        logic [GPIO_CH-1:0] gout;
        logic [GPIO_CH-1:0] gin;
        logic               illegal;
    } ex_ctrl_t;

    ex_ctrl_t        dec;
    ex_ctrl_t        ex_d, ex_q;
    logic            hilo_use;   // instruction needs hi/lo to be settled
    logic            is_mult;
    logic            bad;

    logic [MW-1:0]   mcnt_d, mcnt_q;
    logic [0:0]      state_d, state_q;

    logic            taken;
    logic            squash;
    logic            load;

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      rd;
    logic [4:0]      sh;

    assign op    = instruction[31:26];
    assign funct = instruction[5:0];
    assign rd    = instruction[15:11];
    assign sh    = instruction[10:6];

    // ------------------------------------------------------------------
    // Combinational decode of the instruction at the input
    // ------------------------------------------------------------------
    always_comb begin
        dec      = '0;
        hilo_use = 1'b0;
        is_mult  = 1'b0;
        bad      = 1'b0;

        if (instruction == 32'h0) begin
            // NOP: occupies the slot but does nothing
            dec.valid = 1'b1;
        end else begin
            dec.valid = 1'b1;
            case (op)
                OP_RTYPE: begin
                    case (funct)
                        FN_ADD, FN_ADDU: begin dec.alu_op = 4'b0100; dec.regwrite = 1'b1; end
                        FN_SUB, FN_SUBU: begin dec.alu_op = 4'b0101; dec.regwrite = 1'b1; end
                        FN_AND:  begin dec.alu_op = 4'b0000; dec.regwrite = 1'b1; end
                        FN_OR:   begin dec.alu_op = 4'b0001; dec.regwrite = 1'b1; end
                        FN_NOR:  begin dec.alu_op = 4'b0010; dec.regwrite = 1'b1; end
                        FN_XOR:  begin dec.alu_op = 4'b0011; dec.regwrite = 1'b1; end
                        FN_SLT:  begin dec.alu_op = 4'b1100; dec.regwrite = 1'b1; end
                        FN_SLTU: begin dec.alu_op = 4'b1101; dec.regwrite = 1'b1; end
                        FN_SLL: begin
                            dec.alu_op   = 4'b1000;
                            dec.shamt    = sh;
                            dec.regwrite = 1'b1;
                        end
                        // srl/sra with a zero shift are repurposed as GPIO
                        // write/read on channel rd.
                        FN_SRL: begin
                            if (sh == 5'd0) begin
                                if (32'(rd) < GPIO_CH) dec.gout = CH_ONE << rd;
                                else                   bad      = 1'b1;
                            end else begin
                                dec.alu_op   = 4'b1001;
                                dec.shamt    = sh;
                                dec.regwrite = 1'b1;
                            end
                        end
                        FN_SRA: begin
                            if (sh == 5'd0) begin
                                if (32'(rd) < GPIO_CH) begin
                                    dec.gin      = CH_ONE << rd;
                                    dec.regsel   = 2'd3;
                                    dec.regwrite = 1'b1;
                                end else begin
                                    bad = 1'b1;
                                end
                            end else begin
                                dec.alu_op   = 4'b1010;
                                dec.shamt    = sh;
                                dec.regwrite = 1'b1;
                            end
                        end
                        FN_MFHI: begin
                            dec.regsel   = 2'd1;
                            dec.regwrite = 1'b1;
                            hilo_use     = 1'b1;
                        end
                        FN_MFLO: begin
                            dec.regsel   = 2'd2;
                            dec.regwrite = 1'b1;
                            hilo_use     = 1'b1;
                        end
                        FN_MULT, FN_MULTU: begin
                            dec.alu_op = (funct == FN_MULT) ? 4'b0110 : 4'b0111;
                            dec.enhilo = 1'b1;
                            hilo_use   = 1'b1;
                            is_mult    = 1'b1;
                        end
                        default: bad = 1'b1;
                    endcase
                end
                OP_ADDI, OP_ADDIU: begin
                    dec.alu_op   = 4'b0100;
                    dec.alu_src  = 2'd1;
                    dec.rdrt     = 1'b1;
                    dec.regwrite = 1'b1;
                end
                OP_ORI: begin
                    dec.alu_op   = 4'b0001;
                    dec.alu_src  = 2'd2;
                    dec.rdrt     = 1'b1;
                    dec.regwrite = 1'b1;
                end
                OP_LUI: begin
                    dec.alu_op   = 4'b1000;
                    dec.shamt    = 5'd16;
                    dec.alu_src  = 2'd2;
                    dec.rdrt     = 1'b1;
                    dec.regwrite = 1'b1;
                end
                OP_BEQ: begin dec.alu_op = 4'b0101; dec.is_beq = 1'b1; end
                OP_BNE: begin dec.alu_op = 4'b0101; dec.is_bne = 1'b1; end
                default: bad = 1'b1;
            endcase

            // Illegal encodings occupy the slot but must not write anything
            if (bad) begin
                dec         = '0;
                dec.valid   = 1'b1;
                dec.illegal = 1'b1;
                hilo_use    = 1'b0;
                is_mult     = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Branch resolution, squash, interlock
    // ------------------------------------------------------------------
    // The branch flags live in ex_q, so the FSM only needs to know whether
    // the EX slot is currently being resolved.
    assign taken  = (state_q == S_RESOLVE) &&
                    ((ex_q.is_beq & zero_EX) | (ex_q.is_bne & ~zero_EX));
    assign squash = taken && (DELAY_SLOT == 0);

    // Squash wins over the hi/lo interlock: the held instruction is on the
    // wrong path anyway, so fetch must be free to redirect.
    assign stall_out = instr_valid & hilo_use & (mcnt_q != '0) & ~squash;
    assign load      = instr_valid & ~stall_out & ~squash;

    assign ex_d = load ? dec : '0;

    always_comb begin
        mcnt_d = mcnt_q;
        if (load && is_mult)   mcnt_d = MW'(MULT_LAT - 1);
        else if (mcnt_q != '0) mcnt_d = mcnt_q - MW'(1);
    end

    // A branch that loads while another resolves simply re-enters RESOLVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (load && (dec.is_beq || dec.is_bne)) state_d = S_RESOLVE;
            S_RESOLVE: state_d = (load && (dec.is_beq || dec.is_bne)) ? S_RESOLVE : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mcnt_q  <= '0;
            state_q <= S_IDLE;
        end else begin
            ex_q    <= ex_d;
            mcnt_q  <= mcnt_d;
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign valid_EX    = ex_q.valid;
    assign alu_op      = ex_q.alu_op;
    assign shamt_EX    = ex_q.shamt;
    assign regsel_EX   = ex_q.regsel;
    assign enhilo_EX   = ex_q.enhilo;
    assign regwrite_EX = ex_q.regwrite;
    assign rdrt_EX     = ex_q.rdrt;
    assign alu_src_EX  = ex_q.alu_src;
    assign gpio_out_en = ex_q.gout;
    assign gpio_in_en  = ex_q.gin;
    assign illegal_EX  = ex_q.illegal;
    assign pc_src_EX   = {1'b0, taken};

endmodule
